// File: rtl/nv_nvdla_mcif_write_eg_rsp.sv
// MCIF write-response egress: holds one AXI B response, pops the matching
// per-thread context entry, then releases the burst length and pulses completion.
module nv_nvdla_mcif_write_eg_rsp #(
    parameter int NUM_THREADS = 5,
    parameter int AXID_W      = 8
) (
    input  logic                     nvdla_core_clk,
    input  logic                     nvdla_core_rstn,
    input  logic                     noc2mcif_axi_b_bvalid,
    output logic                     noc2mcif_axi_b_bready,
    input  logic [AXID_W-1:0]        noc2mcif_axi_b_bid,
    input  logic [1:0]               noc2mcif_axi_b_bresp,
    input  logic [NUM_THREADS-1:0]   cq_rd_pvld,
    output logic [NUM_THREADS-1:0]   cq_rd_prdy,
    input  logic [3*NUM_THREADS-1:0] cq_rd_pd,
    output logic                     eg2ig_axi_vld,
    output logic [1:0]               eg2ig_axi_len,
    output logic [NUM_THREADS-1:0]   mcif2client_wr_rsp_complete,
    output logic                     eg_err_illegal_id,
    output logic                     eg_err_bresp
);

    logic                   hold_vld;
    logic [3:0]             hold_tid;
    logic [1:0]             hold_resp;

    logic [NUM_THREADS-1:0] pop_vec;
    logic [2:0]             sel_pd;
    logic                   tid_illegal;
    logic                   legal_drain;
    logic                   drain;
    logic                   b_fire;

    // Upper id bits carry no thread information and are deliberately ignored.
    logic unused_bid_hi;
    assign unused_bid_hi = ^noc2mcif_axi_b_bid[AXID_W-1:4];

    always_comb begin
        pop_vec = '0;
        sel_pd  = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            if (hold_vld && (hold_tid == 4'(t))) begin
                pop_vec[t] = cq_rd_pvld[t];
                sel_pd     = cq_rd_pd[3*t +: 3];
            end
        end
    end

    assign tid_illegal           = hold_tid >= 4'(NUM_THREADS);
    assign legal_drain           = |pop_vec;
    assign drain                 = legal_drain | (hold_vld & tid_illegal);
    assign cq_rd_prdy            = pop_vec;
    assign noc2mcif_axi_b_bready = ~hold_vld | drain;
    assign b_fire                = noc2mcif_axi_b_bvalid & noc2mcif_axi_b_bready;

    // Holding stage: load and drain may coincide for one response per cycle.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            hold_vld  <= 1'b0;
            hold_tid  <= '0;
            hold_resp <= '0;
        end else begin
            if (b_fire) begin
                hold_vld  <= 1'b1;
                hold_tid  <= noc2mcif_axi_b_bid[3:0];
                hold_resp <= noc2mcif_axi_b_bresp;
            end else if (drain) begin
                hold_vld  <= 1'b0;
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            eg2ig_axi_vld               <= 1'b0;
            eg2ig_axi_len               <= '0;
            mcif2client_wr_rsp_complete <= '0;
        end else begin
            eg2ig_axi_vld               <= legal_drain;
            eg2ig_axi_len               <= legal_drain ? sel_pd[2:1] : 2'b00;
            mcif2client_wr_rsp_complete <= sel_pd[0] ? pop_vec : '0;
        end
    end

    // Sticky status; cleared only by reset.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            eg_err_illegal_id <= 1'b0;
            eg_err_bresp      <= 1'b0;
        end else begin
            if (hold_vld && tid_illegal)
                eg_err_illegal_id <= 1'b1;
            if (drain && (hold_resp != 2'b00))
                eg_err_bresp <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nv_nvdla_mcif_write_eg_rsp.sv
// Bench for the MCIF write-response egress: directed scenarios plus a
// randomized run scored against an in-order response/context-queue model.
module tb_nv_nvdla_mcif_write_eg_rsp;

    localparam int NT = 5;

    logic        clk = 1'b0;
    logic        rstn;
    logic        bvalid;
    logic        bready;
    logic [7:0]  bid;
    logic [1:0]  bresp;
    logic [4:0]  pvld;
    logic [4:0]  prdy;
    logic [14:0] pd;
    logic        avld;
    logic [1:0]  alen;
    logic [4:0]  cmp;
    logic        err_ill;
    logic        err_br;

    // Bench-owned context queues: entry = {len[1:0], ack}
    logic [2:0] ent [NT][256];
    logic [7:0] ptr [NT] = '{default: 8'd0};
    logic [7:0] cnt [NT] = '{default: 8'd0};
    logic [4:0] pv_en;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] tid;
        logic [1:0] resp;
    } rsp_t;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NT; g++) begin : g_cq
        assign pvld[g]        = pv_en[g] && (ptr[g] < cnt[g]);
        assign pd[3*g +: 3]   = ent[g][ptr[g]];
        always @(posedge clk) if (prdy[g] && pvld[g]) ptr[g] <= ptr[g] + 8'd1;
    end

    nv_nvdla_mcif_write_eg_rsp #(.NUM_THREADS(NT), .AXID_W(8)) dut (
        .nvdla_core_clk              (clk),
        .nvdla_core_rstn             (rstn),
        .noc2mcif_axi_b_bvalid       (bvalid),
        .noc2mcif_axi_b_bready       (bready),
        .noc2mcif_axi_b_bid          (bid),
        .noc2mcif_axi_b_bresp        (bresp),
        .cq_rd_pvld                  (pvld),
        .cq_rd_prdy                  (prdy),
        .cq_rd_pd                    (pd),
        .eg2ig_axi_vld               (avld),
        .eg2ig_axi_len               (alen),
        .mcif2client_wr_rsp_complete (cmp),
        .eg_err_illegal_id           (err_ill),
        .eg_err_bresp                (err_br)
    );

    task automatic push_cq(input int t, input logic [2:0] e);
        ent[t][cnt[t]] = e;
        cnt[t] = cnt[t] + 8'd1;
    endtask

    task automatic drive_b(input logic v, input logic [7:0] id, input logic [1:0] r);
        bvalid = v;
        bid    = v ? id : 8'hxx;
        bresp  = v ? r : 2'bxx;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (prdy !== 5'b0) begin errors++; $display("FAIL rst_prdy got %b exp 00000", prdy); end
        checks++; if (avld !== 1'b0) begin errors++; $display("FAIL rst_vld got %b exp 0", avld); end
        checks++; if (alen !== 2'b0) begin errors++; $display("FAIL rst_len got %b exp 00", alen); end
        checks++; if (cmp !== 5'b0) begin errors++; $display("FAIL rst_cmp got %b exp 00000", cmp); end
        checks++; if ({err_ill, err_br} !== 2'b00) begin errors++; $display("FAIL rst_err got %b exp 00", {err_ill, err_br}); end
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checks++; if (bready !== 1'b1) begin errors++; $display("FAIL rst_bready got %b exp 1", bready); end
    endtask

    task automatic test_single;
        push_cq(1, 3'b111);
        @(negedge clk); drive_b(1'b1, 8'h01, 2'b00); #1;
        checks++; if (bready !== 1'b1) begin errors++; $display("FAIL t1_bready got %b exp 1", bready); end
        @(negedge clk); drive_b(1'b0, 8'h00, 2'b00); #1;
        checks++; if (prdy !== 5'b00010) begin errors++; $display("FAIL t1_prdy got %b exp 00010", prdy); end
        checks++; if (avld !== 1'b0) begin errors++; $display("FAIL t1_early_vld got %b exp 0", avld); end
        @(negedge clk); #1;
        checks++; if (avld !== 1'b1) begin errors++; $display("FAIL t1_vld got %b exp 1", avld); end
        checks++; if (alen !== 2'd3) begin errors++; $display("FAIL t1_len got %0d exp 3", alen); end
        checks++; if (cmp !== 5'b00010) begin errors++; $display("FAIL t1_cmp got %b exp 00010", cmp); end
        @(negedge clk); #1;
        checks++; if ({avld, cmp} !== 6'b0) begin errors++; $display("FAIL t1_deassert got %b exp 000000", {avld, cmp}); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] ids [3];
        logic [1:0] lens [3];
        ids  = '{8'h00, 8'h52, 8'hA4};
        lens = '{2'd1, 2'd2, 2'd3};
        push_cq(0, 3'b010);
        push_cq(2, 3'b100);
        push_cq(4, 3'b110);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c < 3) drive_b(1'b1, ids[c], 2'b00); else drive_b(1'b0, 8'h00, 2'b00);
            #1;
            if (c < 3) begin
                checks++; if (bready !== 1'b1) begin errors++; $display("FAIL t2_bready c%0d got %b exp 1", c, bready); end
            end
            checks++; if (avld !== (c >= 2 && c <= 4)) begin errors++; $display("FAIL t2_vld c%0d got %b", c, avld); end
            if (c >= 2 && c <= 4) begin
                checks++; if (alen !== lens[c-2]) begin errors++; $display("FAIL t2_len c%0d got %0d exp %0d", c, alen, lens[c-2]); end
            end
            checks++; if (cmp !== 5'b0) begin errors++; $display("FAIL t2_cmp c%0d got %b exp 00000", c, cmp); end
        end
    endtask

    task automatic test_cq_empty;
        pv_en[3] = 1'b0;
        push_cq(3, 3'b101);
        @(negedge clk); drive_b(1'b1, 8'h03, 2'b00); #1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk); drive_b(1'b0, 8'h00, 2'b00); #1;
            checks++; if (bready !== 1'b0) begin errors++; $display("FAIL t3_stall_bready c%0d got %b exp 0", c, bready); end
            checks++; if (prdy !== 5'b0) begin errors++; $display("FAIL t3_stall_prdy c%0d got %b exp 00000", c, prdy); end
        end
        @(negedge clk); pv_en[3] = 1'b1; #1;
        checks++; if (prdy !== 5'b01000) begin errors++; $display("FAIL t3_prdy got %b exp 01000", prdy); end
        checks++; if (bready !== 1'b1) begin errors++; $display("FAIL t3_bready got %b exp 1", bready); end
        @(negedge clk); #1;
        checks++; if ({avld, alen, cmp} !== {1'b1, 2'd2, 5'b01000}) begin
            errors++; $display("FAIL t3_release got %b/%0d/%b exp 1/2/01000", avld, alen, cmp);
        end
    endtask

    task automatic test_illegal_id;
        push_cq(0, 3'b011);
        @(negedge clk); drive_b(1'b1, 8'hF7, 2'b00); #1;
        @(negedge clk); drive_b(1'b0, 8'h00, 2'b00); #1;
        checks++; if (prdy !== 5'b0) begin errors++; $display("FAIL t4_prdy got %b exp 00000", prdy); end
        checks++; if (bready !== 1'b1) begin errors++; $display("FAIL t4_bready got %b exp 1", bready); end
        @(negedge clk); drive_b(1'b1, 8'h30, 2'b00); #1;
        checks++; if (avld !== 1'b0) begin errors++; $display("FAIL t4_vld got %b exp 0", avld); end
        checks++; if (err_ill !== 1'b1) begin errors++; $display("FAIL t4_err got %b exp 1", err_ill); end
        @(negedge clk); drive_b(1'b0, 8'h00, 2'b00); #1;
        checks++; if (prdy !== 5'b00001) begin errors++; $display("FAIL t4_next_prdy got %b exp 00001", prdy); end
        @(negedge clk); #1;
        checks++; if ({avld, alen, cmp} !== {1'b1, 2'd1, 5'b00001}) begin
            errors++; $display("FAIL t4_next_release got %b/%0d/%b exp 1/1/00001", avld, alen, cmp);
        end
        checks++; if (err_ill !== 1'b1) begin errors++; $display("FAIL t4_sticky got %b exp 1", err_ill); end
        checks++; if (err_br !== 1'b0) begin errors++; $display("FAIL t4_err_br got %b exp 0", err_br); end
    endtask

    task automatic test_bresp_err;
        push_cq(2, 3'b100);
        @(negedge clk); drive_b(1'b1, 8'h02, 2'b10); #1;
        @(negedge clk); drive_b(1'b0, 8'h00, 2'b00); #1;
        checks++; if (prdy !== 5'b00100) begin errors++; $display("FAIL t5_prdy got %b exp 00100", prdy); end
        @(negedge clk); #1;
        checks++; if ({avld, alen} !== {1'b1, 2'd2}) begin errors++; $display("FAIL t5_release got %b/%0d exp 1/2", avld, alen); end
        checks++; if (err_br !== 1'b1) begin errors++; $display("FAIL t5_err got %b exp 1", err_br); end
    endtask

    task automatic test_reset_midop;
        pv_en = 5'b11101;
        push_cq(0, 3'b001);
        push_cq(1, 3'b011);
        @(negedge clk); drive_b(1'b1, 8'h00, 2'b00); #1;
        @(negedge clk); drive_b(1'b1, 8'h01, 2'b00); #1;
        checks++; if (prdy !== 5'b00001) begin errors++; $display("FAIL t6_prdy got %b exp 00001", prdy); end
        @(negedge clk); drive_b(1'b0, 8'h00, 2'b00); #1;
        checks++; if ({avld, cmp, bready} !== {1'b1, 5'b00001, 1'b0}) begin
            errors++; $display("FAIL t6_pending got %b/%b/%b exp 1/00001/0", avld, cmp, bready);
        end
        rstn = 1'b0;
        #1;
        checks++; if ({avld, alen, cmp, prdy} !== 13'b0) begin
            errors++; $display("FAIL t6_async_clear got %b/%b/%b/%b exp zeros", avld, alen, cmp, prdy);
        end
        checks++; if ({err_ill, err_br} !== 2'b00) begin errors++; $display("FAIL t6_err_clear got %b exp 00", {err_ill, err_br}); end
        @(negedge clk); rstn = 1'b1; pv_en = 5'b11111;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if ({avld, cmp, prdy, bready} !== {11'b0, 1'b1}) begin
                errors++; $display("FAIL t6_stale c%0d got %b/%b/%b/%b exp 0/0/0/1", c, avld, cmp, prdy, bready);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random;
        rsp_t       q[$];
        rsp_t       h;
        logic       v;
        logic [3:0] tid;
        logic [7:0] id;
        logic [1:0] r;
        logic       exp_v, exp_ill, exp_br, head_drains, exp_rdy;
        logic [1:0] exp_l;
        logic [4:0] exp_c, exp_prdy;
        logic [2:0] e;
        exp_v = 0; exp_l = 0; exp_c = 0; exp_ill = 0; exp_br = 0;
        for (int t = 0; t < NT; t++)
            for (int k = 0; k < 80; k++) push_cq(t, 3'($urandom));
        for (int cyc = 0; cyc < 430; cyc++) begin
            @(negedge clk);
            if (cyc < 400) begin
                v     = ($urandom_range(0, 9) < 6);
                tid   = 4'($urandom_range(0, 7));
                id    = {4'($urandom), tid};
                r     = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                pv_en = 5'($urandom) | 5'($urandom);
            end else begin
                v = 0; id = 0; r = 0;
                pv_en = 5'b11111;
            end
            drive_b(v, id, r);
            #1;
            checks++; if ({avld, alen, cmp} !== {exp_v, exp_l, exp_c}) begin
                errors++; $display("FAIL rnd_out cyc%0d got %b/%0d/%b exp %b/%0d/%b", cyc, avld, alen, cmp, exp_v, exp_l, exp_c);
            end
            checks++; if ({err_ill, err_br} !== {exp_ill, exp_br}) begin
                errors++; $display("FAIL rnd_err cyc%0d got %b exp %b", cyc, {err_ill, err_br}, {exp_ill, exp_br});
            end
            head_drains = 0;
            exp_prdy    = 0;
            if (q.size() > 0) begin
                h = q[0];
                if (h.tid >= 4'(NT)) head_drains = 1;
                else if (pvld[h.tid]) begin
                    head_drains = 1;
                    exp_prdy[h.tid] = 1'b1;
                end
            end
            exp_rdy = (q.size() == 0) || head_drains;
            checks++; if (prdy !== exp_prdy) begin errors++; $display("FAIL rnd_prdy cyc%0d got %b exp %b", cyc, prdy, exp_prdy); end
            checks++; if (bready !== exp_rdy) begin errors++; $display("FAIL rnd_bready cyc%0d got %b exp %b", cyc, bready, exp_rdy); end
            exp_v = 0; exp_l = 0; exp_c = 0;
            if (head_drains) begin
                h = q.pop_front();
                if (h.tid >= 4'(NT)) exp_ill = 1;
                else begin
                    e     = ent[h.tid][ptr[h.tid]];
                    exp_v = 1;
                    exp_l = e[2:1];
                    exp_c = e[0] ? (5'b00001 << h.tid) : 5'b0;
                end
                if (h.resp != 2'b00) exp_br = 1;
            end
            if (v && exp_rdy) q.push_back({id[3:0], r});
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_drain got %0d pending exp 0", q.size()); end
    endtask

    initial begin
        rstn   = 1'b0;
        pv_en  = 5'b11111;
        drive_b(1'b0, 8'h00, 2'b00);
        test_reset;
        test_single;
        test_back_to_back;
        test_cq_empty;
        test_illegal_id;
        test_bresp_err;
        test_reset_midop;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired after %0t", $time);
        $fatal(1);
    end

endmodule
